// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control FSM: state enum,
// opcode constants, ALUOp codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [1:0] ALUOP_BR    = 2'b00;
   localparam logic [1:0] ALUOP_ADDR  = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts memory wait cycles while a request is outstanding and flags a
// timeout on the last allowed cycle unless mem_ready arrives in that cycle.
module mc_mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int CW = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle that is not a stalled wait ends or leaves the access, so the
   // count returns to zero and is clean on entry to the next wait state.
   always_comb begin
      timeout = active & ~mem_ready & (cnt_q == LAST);
      cnt_d   = '0;
      if (active && !mem_ready && !timeout) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle core: sequences fetch/decode/execute/
// memory/writeback, handles memory waits and timeouts, counts retired instructions.
module multi_cycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             zero,
   input  logic             lt,
   input  logic             mem_ready,
   output logic [1:0]       ALUOp,
   output logic [3:0]       Funct,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             bus_error,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             wait_active;
   logic             timeout;
   logic             retire;

   assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   mc_mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .active   (wait_active),
      .mem_ready(mem_ready),
      .timeout  (timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      ALUOp      = ALUOP_BR;
      Funct      = {funct7b5 & (opcode == OP_RTYPE), funct3};
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      bus_error  = timeout;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
            ALUOp     = ALUOP_ADDR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_ADDR;
            case (opcode)
               OP_RTYPE:           state_d = S_EXEC_R;
               OP_ITYPE:           state_d = S_EXEC_I;
               OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
               OP_BRANCH:          state_d = S_BRANCH;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            ALUOp     = ALUOP_RTYPE;
            state_d   = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_RTYPE;
            Funct[3]  = 1'b0;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            ALUOp     = ALUOP_ADDR;
            state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (timeout) begin
               state_d = S_FETCH;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (timeout) begin
               state_d = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            ALUOp     = ALUOP_BR;
            pc_src    = 1'b1;
            state_d   = S_FETCH;
            if (funct3 == F3_BEQ) begin
               pc_write = zero;
               retire   = 1'b1;
            end else if (funct3 == F3_BGE) begin
               pc_write = ~lt;
               retire   = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // Enables must fall the moment reset rises, not at the next edge.
      if (reset) begin
         ALUOp      = '0;
         Funct      = '0;
         alu_src_a  = '0;
         alu_src_b  = '0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         iord       = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 1'b0;
         reg_write  = 1'b0;
         mem_to_reg = 1'b0;
         bus_error  = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: an instruction-level model predicts
// cycle counts, enable pulse counts and retire count per instruction.
module tb_multi_cycle_control;

   localparam int T    = 4;
   localparam int CW   = 4;
   localparam logic [6:0] OPR = 7'b0110011;
   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPL = 7'b0000011;
   localparam logic [6:0] OPS = 7'b0100011;
   localparam logic [6:0] OPB = 7'b1100011;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7b5, zero, lt, mem_ready;
   logic [1:0]    ALUOp, alu_src_a, alu_src_b;
   logic [3:0]    Funct;
   logic          mem_read, mem_write, iord, ir_write, pc_write, pc_src;
   logic          reg_write, mem_to_reg, bus_error, illegal;
   logic [CW-1:0] retired;

   int checks = 0;
   int errs   = 0;
   int exp_ret = 0;

   multi_cycle_control #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .lt(lt), .mem_ready(mem_ready), .ALUOp(ALUOp), .Funct(Funct),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_read(mem_read), .mem_write(mem_write),
      .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .bus_error(bus_error),
      .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({ALUOp, Funct, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write,
                  pc_write, pc_src, reg_write, mem_to_reg, bus_error, illegal});
   endfunction

   function automatic logic [31:0] ret_mod();
      return 32'(exp_ret % (1 << CW));
   endfunction

   // One instruction: wf/wm are cycles of mem_ready low before it rises
   // in the fetch / data access; T or more means the access times out.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic l, input int wf, input int wm);
      logic q[$];
      int   exec_idx = -1;
      bit   fok, mok, is_r, is_i, is_ld, is_st, is_br;
      int   flen, mlen;
      int   e_mrd, e_mwr, e_ir, e_pcw, e_rw, e_mtr, e_ill, e_berr, e_pcs, e_ret;
      int   c_mrd = 0, c_mwr = 0, c_ir = 0, c_pcw = 0, c_rw = 0, c_mtr = 0;
      int   c_ill = 0, c_berr = 0, c_pcs = 0;
      logic [1:0] e_aluop, e_srcb;
      logic [3:0] e_funct;

      opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l;
      is_r = (op == OPR); is_i = (op == OPI); is_ld = (op == OPL);
      is_st = (op == OPS); is_br = (op == OPB);
      fok  = (wf < T);
      flen = fok ? wf + 1 : T;
      for (int i = 0; i < flen; i++) q.push_back(i == wf);
      e_mrd = flen; e_mwr = 0; e_ir = int'(fok); e_pcw = int'(fok); e_rw = 0; e_mtr = 0;
      e_ill = 0; e_berr = int'(!fok); e_pcs = 0; e_ret = 0;
      e_aluop = 2'b00; e_srcb = 2'b00; e_funct = {1'b0, f3};
      if (fok) begin
         q.push_back(1'($urandom_range(0, 1)));
         if (is_r || is_i) begin
            exec_idx = q.size();
            q.push_back(1'($urandom_range(0, 1)));
            q.push_back(1'($urandom_range(0, 1)));
            e_rw = 1; e_ret = 1; e_aluop = 2'b10;
            e_srcb = is_r ? 2'b00 : 2'b10;
            e_funct = {is_r & f7, f3};
         end else if (is_br) begin
            exec_idx = q.size();
            q.push_back(1'($urandom_range(0, 1)));
            e_pcs = 1; e_aluop = 2'b00; e_srcb = 2'b00;
            if (f3 == 3'b000) begin
               e_ret = 1; e_pcw += int'(z);
            end else if (f3 == 3'b101) begin
               e_ret = 1; e_pcw += int'(!l);
            end else begin
               e_ill = 1;
            end
         end else if (is_ld || is_st) begin
            exec_idx = q.size();
            q.push_back(1'($urandom_range(0, 1)));
            e_aluop = 2'b01; e_srcb = 2'b10;
            mok  = (wm < T);
            mlen = mok ? wm + 1 : T;
            for (int i = 0; i < mlen; i++) q.push_back(i == wm);
            if (is_st) e_mwr = mlen;
            else       e_mrd += mlen;
            if (!mok) begin
               e_berr = 1;
            end else begin
               e_ret = 1;
               if (is_ld) begin
                  q.push_back(1'($urandom_range(0, 1)));
                  e_rw = 1; e_mtr = 1;
               end
            end
         end else begin
            e_ill = 1;
         end
      end

      for (int c = 0; c < q.size(); c++) begin
         mem_ready = q[c];
         @(negedge clk);
         if (c == 0)
            check_val("fetch_start", 32'({mem_read, iord, alu_src_a, alu_src_b}), 32'(6'b100001));
         if (c == exec_idx) begin
            check_val("exec_aluop", 32'(ALUOp), 32'(e_aluop));
            check_val("exec_srcb", 32'(alu_src_b), 32'(e_srcb));
            check_val("exec_funct", 32'(Funct), 32'(e_funct));
         end
         c_mrd += int'(mem_read);  c_mwr += int'(mem_write); c_ir += int'(ir_write);
         c_pcw += int'(pc_write);  c_rw += int'(reg_write);  c_mtr += int'(mem_to_reg);
         c_ill += int'(illegal);   c_berr += int'(bus_error); c_pcs += int'(pc_src);
         @(posedge clk);
         #1;
      end
      exp_ret += e_ret;
      check_val("n_mem_read", 32'(c_mrd), 32'(e_mrd));
      check_val("n_mem_write", 32'(c_mwr), 32'(e_mwr));
      check_val("n_ir_write", 32'(c_ir), 32'(e_ir));
      check_val("n_pc_write", 32'(c_pcw), 32'(e_pcw));
      check_val("n_reg_write", 32'(c_rw), 32'(e_rw));
      check_val("n_mem_to_reg", 32'(c_mtr), 32'(e_mtr));
      check_val("n_illegal", 32'(c_ill), 32'(e_ill));
      check_val("n_bus_error", 32'(c_berr), 32'(e_berr));
      check_val("n_pc_src", 32'(c_pcs), 32'(e_pcs));
      check_val("retired", 32'(retired), ret_mod());
   endtask

   task automatic tick_rdy(input logic r);
      mem_ready = r;
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] op;
      int sel, wf, wm;

      reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
      zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_val("reset_outs", all_outs(), 32'h0);
      check_val("reset_retired", 32'(retired), 32'h0);
      reset = 1'b0;

      // Directed cases
      run_instr(OPR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(OPR, 3'b000, 1'b1, 1'b0, 1'b0, 1, 0);
      run_instr(OPI, 3'b010, 1'b1, 1'b0, 1'b0, 0, 0);
      run_instr(OPL, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
      run_instr(OPS, 3'b010, 1'b0, 1'b0, 1'b0, 0, 1);
      run_instr(OPB, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
      run_instr(OPB, 3'b101, 1'b0, 1'b0, 1'b1, 0, 0);
      run_instr(OPB, 3'b011, 1'b0, 1'b1, 1'b0, 0, 0);
      run_instr(OPR, 3'b000, 1'b0, 1'b0, 1'b0, T, 0);
      run_instr(OPR, 3'b000, 1'b0, 1'b0, 1'b0, T - 1, 0);
      run_instr(OPL, 3'b010, 1'b0, 1'b0, 1'b0, 0, T + 1);
      run_instr(OPS, 3'b010, 1'b0, 1'b0, 1'b0, 0, T);
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 5);
         wf  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
         wm  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
         case (sel)
            0: op = OPR;
            1: op = OPI;
            2: op = OPL;
            3: op = OPS;
            4: op = OPB;
            default: begin
               op = 7'($urandom_range(0, 127));
               while (op == OPR || op == OPI || op == OPL || op == OPS || op == OPB)
                  op = 7'($urandom_range(0, 127));
            end
         endcase
         run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wf, wm);
      end

      // Reset in the middle of a stalled store
      opcode = OPS; funct3 = 3'b010;
      tick_rdy(1'b1);
      tick_rdy(1'b0);
      tick_rdy(1'b0);
      tick_rdy(1'b0);
      mem_ready = 1'b0;
      @(negedge clk);
      check_val("mid_wr_mem_write", 32'(mem_write), 32'h1);
      reset = 1'b1;
      #1;
      check_val("async_reset_outs", all_outs(), 32'h0);
      check_val("async_reset_retired", 32'(retired), 32'h0);
      exp_ret = 0;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int n = 0; n < 16; n++)
         run_instr(OPR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
      check_val("retired_wrap", 32'(retired), 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
